ula_seq: RTL and testbench

- Execute-stage ALU. Sits directly downstream of ula_control and consumes its 4-bit ula_select code plus two operands.
- Arithmetic, compare and logic ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, to save area.
- Valid/ready handshakes on the input and output sides let the pipeline stall around multi-cycle shifts.

---
 rtl/ula_pkg.sv | 30 +++
 rtl/ula_comb.sv | 36 +++
 rtl/ula_seq.sv | 150 +++++++++++++++
 tb/tb_ula_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// ula_pkg: operation codes shared with ula_control, FSM state encoding and
// the default datapath width used by ula_comb and ula_seq.
package ula_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ULA_ADD  = 4'd1;
  localparam logic [3:0] ULA_SUB  = 4'd2;
  localparam logic [3:0] ULA_SLL  = 4'd3;
  localparam logic [3:0] ULA_SLT  = 4'd4;
  localparam logic [3:0] ULA_SLTU = 4'd5;
  localparam logic [3:0] ULA_SRL  = 4'd6;
  localparam logic [3:0] ULA_SRA  = 4'd7;
  localparam logic [3:0] ULA_XOR  = 4'd8;
  localparam logic [3:0] ULA_OR   = 4'd9;
  localparam logic [3:0] ULA_AND  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ULA_SLL) || (sel == ULA_SRL) || (sel == ULA_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_comb.sv
`default_nettype none
// ula_comb: single-cycle ADD/SUB/SLT/SLTU/XOR/OR/AND. Shift codes and
// illegal codes yield zero here; shifts are resolved inside ula_seq.
module ula_comb
  import ula_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      sel_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  logic slt_flag;
  logic sltu_flag;

  assign slt_flag  = $signed(a_i) < $signed(b_i);
  assign sltu_flag = a_i < b_i;

  always_comb begin
    y_o = '0;
    case (sel_i)
      ULA_ADD:  y_o = a_i + b_i;
      ULA_SUB:  y_o = a_i - b_i;
      ULA_SLT:  y_o = {{(XLEN-1){1'b0}}, slt_flag};
      ULA_SLTU: y_o = {{(XLEN-1){1'b0}}, sltu_flag};
      ULA_XOR:  y_o = a_i ^ b_i;
      ULA_OR:   y_o = a_i | b_i;
      ULA_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ula_seq: execute-stage ALU with valid/ready handshakes and an iterative
// one-bit-per-cycle shifter; define ULA_FAST_SHIFT_EN for a barrel shifter.
module ula_seq
  import ula_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ula_select,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  state_e             state_q;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic [XLEN-1:0]    comb_y;
  logic [XLEN-1:0]    res_d;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

  ula_comb #(.XLEN(XLEN)) u_comb (
    .sel_i (ula_select),
    .a_i   (op_a),
    .b_i   (op_b),
    .y_o   (comb_y)
  );

`ifdef ULA_FAST_SHIFT_EN

  always_comb begin
    res_d = comb_y;
    case (ula_select)
      ULA_SLL: res_d = op_a << shamt;
      ULA_SRL: res_d = op_a >> shamt;
      ULA_SRA: res_d = $unsigned($signed(op_a) >>> shamt);
      default: res_d = comb_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            result_q <= res_d;
            zero_q   <= (res_d == '0);
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`else

  logic [XLEN-1:0]    acc_q;
  logic [XLEN-1:0]    acc_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [3:0]         sel_q;
  logic               shift_op;

  assign shift_op = is_shift(ula_select);

  // A zero-distance shift is a plain pass-through of op_a.
  always_comb begin
    res_d = comb_y;
    if (shift_op) res_d = op_a;
  end

  always_comb begin
    acc_d = acc_q;
    case (sel_q)
      ULA_SLL: acc_d = {acc_q[XLEN-2:0], 1'b0};
      ULA_SRL: acc_d = {1'b0, acc_q[XLEN-1:1]};
      ULA_SRA: acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (shift_op && (shamt != '0)) begin
              acc_q   <= op_a;
              cnt_q   <= shamt;
              sel_q   <= ula_select;
              state_q <= ST_SHIFT;
            end else begin
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              state_q  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// tb_ula_seq: scoreboard bench for ula_seq; directed corner cases then random ops.
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ula_select = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  ula_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ula_select (ula_select),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   seen = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic logic [31:0] ref_res(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = int'(b & 32'h1f);
    case (sel)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a << n;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a >> n;
      4'd7:  return $unsigned($signed(a) >>> n);
      4'd8:  return a ^ b;
      4'd9:  return a | b;
      4'd10: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges between the accept edge and the edge where out_valid rises.
  function automatic int ref_lat(input logic [3:0] sel, input logic [31:0] b);
`ifdef ULA_FAST_SHIFT_EN
    return 0;
`else
    if (sel == 4'd3 || sel == 4'd6 || sel == 4'd7) return int'(b & 32'h1f);
    return 0;
`endif
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    ula_select = sel;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never seen for sel %0d", sel);
    end else begin
      e.res = ref_res(sel, a, b);
      e.acc = cyc + 1;
      e.lat = ref_lat(sel, b);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every cycle an output is presented, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: result %h with nothing pending", result);
      end else begin
        if (!seen) begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
          seen = 1'b1;
        end
        chk("result", result, sb[0].res);
        chk("zero", {31'd0, zero}, {31'd0, sb[0].res == 32'd0});
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle ops and iterative shifts.
    send(4'd1, 32'hFFFF_FFFF, 32'd1);
    drain();
    send(4'd2, 32'd5, 32'd7);
    send(4'd4, 32'hFFFF_FFFF, 32'd1);
    send(4'd5, 32'hFFFF_FFFF, 32'd1);
    send(4'd12, 32'h1234_5678, 32'h0F0F_0F0F);
    send(4'd0, 32'hDEAD_BEEF, 32'd1);
    send(4'd8, 32'hF0F0_0000, 32'h0FF0_1234);
    drain();
    send(4'd7, 32'h8000_0000, 32'd31);
    send(4'd6, 32'h8000_0000, 32'd31);
    send(4'd3, 32'd1, 32'd0);
    send(4'd6, 32'hF000_0000, 32'h25);
    send(4'd3, 32'h8000_0001, 32'hFFFF_FFE1);
    drain();

    // Operands and select scrambled while a shift is in flight.
    send(4'd3, 32'd1, 32'd8);
    for (int i = 0; i < 10; i++) begin
      ula_select = 4'($urandom);
      op_a = $urandom;
      op_b = $urandom;
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: result held, pending op waits until DONE clears.
    out_ready = 1'b0;
    send(4'd1, 32'd3, 32'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    ula_select = 4'd8;
    op_a = 32'h0000_00F0;
    op_b = 32'h0000_000F;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    begin
      exp_t e;
      e.res = 32'h0000_00FF;
      e.acc = cyc + 1;
      e.lat = 0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a long shift discards it.
    send(4'd3, 32'd1, 32'd20);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    seen = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // Random traffic with random gaps and random out_ready.
    rand_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      send(s, a, b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
